// File: rtl/timer_pkg.sv
// Shared types, BCD limits and the mm:ss validity check for the countdown timer.
package timer_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} timer_state_e;

   localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
   localparam logic [3:0]  DIGIT_MAX    = 4'd9;
   localparam logic [15:0] CNT_MAX      = 16'h9959;

   function automatic logic is_valid_mmss(input logic [15:0] i_val);
      return (i_val[15:12] <= DIGIT_MAX) && (i_val[11:8] <= DIGIT_MAX) &&
             (i_val[7:4] <= SEC_TENS_MAX) && (i_val[3:0] <= DIGIT_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrement: wraps 0 to MAX and borrows from the next digit.
module bcd_digit_dec #(
   parameter logic [3:0] MAX = 4'd9
) (
   input  logic [3:0] i_digit,
   input  logic       i_borrow_in,
   output logic [3:0] o_digit,
   output logic       o_borrow_out
);

   always_comb begin
      o_digit      = i_digit;
      o_borrow_out = 1'b0;
      if (i_borrow_in) begin
         if (i_digit == 4'd0) begin
            o_digit      = MAX;
            o_borrow_out = 1'b1;
         end else begin
            o_digit = i_digit - 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_countdown_timer.sv
// BCD mm:ss countdown timer with load/start/pause control and a one-clk timeout pulse.
// Optional bonus-seconds adder is built only when TIMER_BONUS_EN is defined.
module bcd_countdown_timer
   import timer_pkg::*;
#(
   parameter logic [15:0] PRESET    = 16'h0100,
   parameter logic [7:0]  BONUS_SEC = 8'h10
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_tick_1s,
   input  logic        i_load,
   input  logic [15:0] i_load_val,
   input  logic        i_start,
   input  logic        i_pause,
   input  logic        i_gameover,
   input  logic        i_bonus,
   output logic [15:0] o_cnt,
   output logic        o_running,
   output logic        o_zero,
   output logic        o_timeout,
   output logic        o_load_err
);

   timer_state_e r_state;
   logic [15:0]  r_cnt;
   logic         r_timeout;
   logic         r_load_err;
   logic [15:0]  w_dec;
   logic [2:0]   w_borrow;
   logic         w_unused_borrow;
   logic         w_bonus_hit;
   logic [15:0]  w_bonus_cnt;

   bcd_digit_dec #(.MAX(DIGIT_MAX)) u_sec_units (
      .i_digit(r_cnt[3:0]), .i_borrow_in(1'b1),
      .o_digit(w_dec[3:0]), .o_borrow_out(w_borrow[0])
   );
   bcd_digit_dec #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .i_digit(r_cnt[7:4]), .i_borrow_in(w_borrow[0]),
      .o_digit(w_dec[7:4]), .o_borrow_out(w_borrow[1])
   );
   bcd_digit_dec #(.MAX(DIGIT_MAX)) u_min_units (
      .i_digit(r_cnt[11:8]), .i_borrow_in(w_borrow[1]),
      .o_digit(w_dec[11:8]), .o_borrow_out(w_borrow[2])
   );
   bcd_digit_dec #(.MAX(DIGIT_MAX)) u_min_tens (
      .i_digit(r_cnt[15:12]), .i_borrow_in(w_borrow[2]),
      .o_digit(w_dec[15:12]), .o_borrow_out(w_unused_borrow)
   );

`ifdef TIMER_BONUS_EN
   logic [15:0] w_base;
   logic [4:0]  w_su, w_st, w_mu, w_mt;

   // Base includes this cycle's tick so bonus and decrement combine in one edge.
   always_comb begin
      w_base = ((r_state == RUN) && i_tick_1s) ? w_dec : r_cnt;
      w_su   = {1'b0, w_base[3:0]} + {1'b0, BONUS_SEC[3:0]};
      w_st   = {1'b0, w_base[7:4]} + {1'b0, BONUS_SEC[7:4]};
      if (w_su > 5'd9) begin
         w_su = w_su - 5'd10;
         w_st = w_st + 5'd1;
      end
      w_mu = {1'b0, w_base[11:8]};
      if (w_st > 5'd5) begin
         w_st = w_st - 5'd6;
         w_mu = w_mu + 5'd1;
      end
      w_mt = {1'b0, w_base[15:12]};
      if (w_mu > 5'd9) begin
         w_mu = w_mu - 5'd10;
         w_mt = w_mt + 5'd1;
      end
      if (w_mt > 5'd9) w_bonus_cnt = CNT_MAX;
      else             w_bonus_cnt = {w_mt[3:0], w_mu[3:0], w_st[3:0], w_su[3:0]};
   end
   assign w_bonus_hit = i_bonus;
`else
   logic w_unused_bonus;
   assign w_unused_bonus = i_bonus & (|BONUS_SEC);
   assign w_bonus_hit    = 1'b0;
   assign w_bonus_cnt    = r_cnt;
`endif

   always_ff @(posedge i_clk) begin
      r_timeout  <= 1'b0;
      r_load_err <= 1'b0;
      if (!i_rst_n) begin
         r_cnt   <= PRESET;
         r_state <= IDLE;
      end else if (i_load) begin
         if (is_valid_mmss(i_load_val)) begin
            r_cnt   <= i_load_val;
            r_state <= IDLE;
         end else begin
            r_load_err <= 1'b1;
         end
      end else if (!i_gameover) begin
         unique case (r_state)
            IDLE: begin
               if (i_start && !i_pause && (r_cnt != 16'h0000)) r_state <= RUN;
            end
            RUN: begin
               if (i_pause) begin
                  r_state <= PAUSED;
               end else if (w_bonus_hit) begin
                  r_cnt <= w_bonus_cnt;
               end else if (i_tick_1s) begin
                  r_cnt <= w_dec;
                  if (r_cnt == 16'h0001) begin
                     r_state   <= EXPIRED;
                     r_timeout <= 1'b1;
                  end
               end
            end
            PAUSED: begin
               if (i_start && !i_pause) r_state <= RUN;
               else if (w_bonus_hit)    r_cnt   <= w_bonus_cnt;
            end
            EXPIRED: ;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_cnt      = r_cnt;
   assign o_running  = (r_state == RUN);
   assign o_zero     = (r_cnt == 16'h0000);
   assign o_timeout  = r_timeout;
   assign o_load_err = r_load_err;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: directed cycles push expectations, a monitor checks.
module tb_bcd_countdown_timer;

   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] LD   = 6'b100000;
   localparam logic [5:0] ST   = 6'b010000;
   localparam logic [5:0] PA   = 6'b001000;
   localparam logic [5:0] TK   = 6'b000100;
   localparam logic [5:0] GO   = 6'b000010;
   localparam logic [5:0] BO   = 6'b000001;

   typedef struct {
      logic [15:0] cnt;
      logic        running;
      logic        zero;
      logic        timeout;
      logic        load_err;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick_1s = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
   logic        gameover = 1'b0, bonus = 1'b0;
   logic [15:0] load_val = 16'h0000;
   logic [15:0] cnt;
   logic        running, zero, timeout, load_err;

   exp_t q[$];
   exp_t m_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   bcd_countdown_timer #(.PRESET(16'h0100), .BONUS_SEC(8'h10)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_tick_1s(tick_1s), .i_load(load),
      .i_load_val(load_val), .i_start(start), .i_pause(pause), .i_gameover(gameover),
      .i_bonus(bonus), .o_cnt(cnt), .o_running(running), .o_zero(zero),
      .o_timeout(timeout), .o_load_err(load_err)
   );

   // Drive one clock of inputs and queue the state expected right after that edge.
   task automatic cyc(input logic [5:0] c, input logic [15:0] lv, input logic [15:0] ecnt,
                      input logic erun, input logic eto, input logic ele, input string nm);
      exp_t e;
      {load, start, pause, tick_1s, gameover, bonus} = c;
      load_val = lv;
      @(posedge clk);
      #1;
      e.cnt = ecnt; e.running = erun; e.zero = (ecnt == 16'h0000);
      e.timeout = eto; e.load_err = ele; e.name = nm;
      q.push_back(e);
      {load, start, pause, tick_1s, gameover, bonus} = NONE;
   endtask

   always @(negedge clk) begin
      while (q.size() > 0) begin
         m_e = q.pop_front();
         n_cmp++;
         if (cnt !== m_e.cnt || running !== m_e.running || zero !== m_e.zero ||
             timeout !== m_e.timeout || load_err !== m_e.load_err) begin
            n_bad++;
            $display("FAIL %s: got cnt=%h run=%b zero=%b to=%b lerr=%b, want cnt=%h run=%b zero=%b to=%b lerr=%b",
                     m_e.name, cnt, running, zero, timeout, load_err,
                     m_e.cnt, m_e.running, m_e.zero, m_e.timeout, m_e.load_err);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      cyc(NONE, 16'h0, 16'h0100, 1'b0, 1'b0, 1'b0, "reset");
      rst_n = 1'b1;
      cyc(ST,   16'h0, 16'h0100, 1'b1, 1'b0, 1'b0, "start");
      cyc(TK,   16'h0, 16'h0059, 1'b1, 1'b0, 1'b0, "tick1");
      cyc(TK,   16'h0, 16'h0058, 1'b1, 1'b0, 1'b0, "tick2");
      cyc(TK,   16'h0, 16'h0057, 1'b1, 1'b0, 1'b0, "tick3");

      cyc(LD,   16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0, "load0002");
      cyc(ST,   16'h0,    16'h0002, 1'b1, 1'b0, 1'b0, "start2");
      cyc(TK,   16'h0,    16'h0001, 1'b1, 1'b0, 1'b0, "to0001");
      cyc(TK,   16'h0,    16'h0000, 1'b0, 1'b1, 1'b0, "expire");
      cyc(NONE, 16'h0,    16'h0000, 1'b0, 1'b0, 1'b0, "to_one_clk");
      cyc(TK,   16'h0,    16'h0000, 1'b0, 1'b0, 1'b0, "no_wrap");
      cyc(ST,   16'h0,    16'h0000, 1'b0, 1'b0, 1'b0, "exp_start_ign");
      cyc(LD,   16'h0070, 16'h0000, 1'b0, 1'b0, 1'b1, "exp_bad_load");

      cyc(LD,   16'h1000, 16'h1000, 1'b0, 1'b0, 1'b0, "load1000");
      cyc(ST,   16'h0,    16'h1000, 1'b1, 1'b0, 1'b0, "start1000");
      cyc(TK,   16'h0,    16'h0959, 1'b1, 1'b0, 1'b0, "borrow0959");
      cyc(LD,   16'h0070, 16'h0959, 1'b1, 1'b0, 1'b1, "bad_sec_tens");
      cyc(NONE, 16'h0,    16'h0959, 1'b1, 1'b0, 1'b0, "lerr_one_clk");
      cyc(LD,   16'h00A0, 16'h0959, 1'b1, 1'b0, 1'b1, "bad_nibble");

      cyc(LD,   16'h0030, 16'h0030, 1'b0, 1'b0, 1'b0, "load0030");
      cyc(ST,   16'h0,    16'h0030, 1'b1, 1'b0, 1'b0, "start0030");
      cyc(PA,   16'h0,    16'h0030, 1'b0, 1'b0, 1'b0, "pause");
      for (int i = 0; i < 5; i++) cyc(TK, 16'h0, 16'h0030, 1'b0, 1'b0, 1'b0, "paused_tick");
      cyc(ST,      16'h0, 16'h0030, 1'b1, 1'b0, 1'b0, "resume");
      cyc(TK,      16'h0, 16'h0029, 1'b1, 1'b0, 1'b0, "tick0029");
      for (int i = 0; i < 3; i++) cyc(GO | TK, 16'h0, 16'h0029, 1'b1, 1'b0, 1'b0, "gameover_tick");
      cyc(GO | PA, 16'h0, 16'h0029, 1'b1, 1'b0, 1'b0, "gameover_pause");
      cyc(ST | PA, 16'h0, 16'h0029, 1'b0, 1'b0, 1'b0, "start_pause");
      cyc(TK,      16'h0, 16'h0029, 1'b0, 1'b0, 1'b0, "paused_again");
      cyc(ST,      16'h0, 16'h0029, 1'b1, 1'b0, 1'b0, "resume2");
      cyc(LD | TK, 16'h0045, 16'h0045, 1'b0, 1'b0, 1'b0, "load_and_tick");
      cyc(TK,      16'h0,    16'h0045, 1'b0, 1'b0, 1'b0, "idle_tick");

      cyc(LD,      16'h2000, 16'h2000, 1'b0, 1'b0, 1'b0, "load2000");
      cyc(ST,      16'h0,    16'h2000, 1'b1, 1'b0, 1'b0, "start2000");
      cyc(TK,      16'h0,    16'h1959, 1'b1, 1'b0, 1'b0, "borrow1959");
      cyc(GO | LD, 16'h0500, 16'h0500, 1'b0, 1'b0, 1'b0, "load_in_gameover");
      cyc(LD,      16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "load0000");
      cyc(ST,      16'h0,    16'h0000, 1'b0, 1'b0, 1'b0, "start_at_zero");

`ifdef TIMER_BONUS_EN
      cyc(LD,      16'h0055, 16'h0055, 1'b0, 1'b0, 1'b0, "b_load0055");
      cyc(BO,      16'h0,    16'h0055, 1'b0, 1'b0, 1'b0, "b_idle_ignored");
      cyc(ST,      16'h0,    16'h0055, 1'b1, 1'b0, 1'b0, "b_start");
      cyc(BO,      16'h0,    16'h0105, 1'b1, 1'b0, 1'b0, "b_carry0105");
      cyc(PA,      16'h0,    16'h0105, 1'b0, 1'b0, 1'b0, "b_pause");
      cyc(BO,      16'h0,    16'h0115, 1'b0, 1'b0, 1'b0, "b_paused0115");
      cyc(LD,      16'h9955, 16'h9955, 1'b0, 1'b0, 1'b0, "b_load9955");
      cyc(ST,      16'h0,    16'h9955, 1'b1, 1'b0, 1'b0, "b_start9955");
      cyc(BO,      16'h0,    16'h9959, 1'b1, 1'b0, 1'b0, "b_saturate");
      cyc(LD,      16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, "b_load0001");
      cyc(ST,      16'h0,    16'h0001, 1'b1, 1'b0, 1'b0, "b_start0001");
      cyc(BO | TK, 16'h0,    16'h0010, 1'b1, 1'b0, 1'b0, "b_tick_no_timeout");
`endif

      cyc(LD,   16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, "load0100");
      cyc(ST,   16'h0,    16'h0100, 1'b1, 1'b0, 1'b0, "start0100");
      cyc(TK,   16'h0,    16'h0059, 1'b1, 1'b0, 1'b0, "tick0059");
      rst_n = 1'b0;
      cyc(LD | ST, 16'h0005, 16'h0100, 1'b0, 1'b0, 1'b0, "reset_over_load");
      rst_n = 1'b1;

      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
